spi_baud_generator: RTL and testbench
=====================================

# spi_baud_generator

Generates the SPI serial clock and the per-edge shift/sample strobes for the master-mode SPI core, driven from the APB-programmed prescaler fields. Sits beside the slave-select stage: it supplies `BaudRateDivisor_o` to that stage and consumes its active-low `ss_i`. It also feeds the shift-register stage with one-PCLK-wide `send_tick_o` / `receive_tick_o` strobes. Transfer length is fixed at 8 SCLK periods (16 half-periods), timed by the slave-select stage.

## Interface
Parameters:
- `DIV_W`, 12, width of the baud-rate divisor.
- `CNT_W`, 11, width of the half-period counter.

Ports (one clock; reset is asynchronous and active-low):
- `PCLK` input 1: system/APB clock; all state on rising edge.
- `PRESET_n` input 1: asynchronous active-low reset.
- `spi_mode_i` input 2: 00 run, 01 wait, 10/11 stop.
- `spiswai_i` input 1: stop-in-wait; gates SCLK when mode is 01.
- `mstr_i` input 1: master enable.
- `cpol_i` input 1: SCLK idle level.
- `cpha_i` input 1: 0 = sample leading edge, 1 = sample trailing edge.
- `sppr_i` input 3: prescaler preselect.
- `spr_i` input 3: prescaler rate select.
- `ss_i` input 1: active-low slave select from the slave-select stage.
- `sclk_o` output 1: serial clock, registered.
- `send_tick_o` output 1: one-cycle strobe, shift MOSI.
- `receive_tick_o` output 1: one-cycle strobe, sample MISO.
- `BaudRateDivisor_o` output 12: `(sppr_i+1) * 2^(spr_i+1)`.

## Operation
- Divisor is combinational: range 2 (sppr=0, spr=0) to 2048 (0x800, sppr=7, spr=7). It always fits 12 bits.
- `half = BaudRateDivisor_o >> 1`, range 1..1024.
- **Enable:** `en = mstr_i & !ss_i & (mode==00 | (mode==01 & !spiswai_i))`.
- **IDLE (en=0):**
  - `count` ← 0.
  - `sclk_o` ← `cpol_i`.
  - Both ticks 0.
- **ACTIVE (en=1):**
  - If `count >= half-1`:
    - `count` ← 0.
    - `sclk_o` ← `~sclk_o`.
    - Assert the tick for the upcoming edge.
  - Otherwise, `count` ← `count+1`.
- **Edge classification**, evaluated in the toggle cycle:
  - A leading edge is one where `sclk_o == cpol_i` before the toggle.
  - `cpha_i=0`: leading → `receive_tick_o`; trailing → `send_tick_o`.
  - `cpha_i=1`: leading → `send_tick_o`; trailing → `receive_tick_o`.
- **Tick rules:**
  - Ticks are registered and assert in the same cycle `sclk_o` changes.
  - The two ticks are never asserted together.
- The `>=` compare guarantees recovery if `sppr_i`/`spr_i` shrink mid-transfer: the next cycle wraps. Software must not change them while `ss_i`=0; there is no other protection.
- `ss_i` rising or `en` dropping mid-transfer:
  - Next cycle: `sclk_o`=`cpol_i`, `count`=0, ticks 0.
  - No partial edge is emitted afterwards.

## Timing
- **Reset values:**
  - `sclk_o`=0.
  - `send_tick_o`=0, `receive_tick_o`=0.
  - `count`=0.
  - After reset release, `sclk_o` reaches `cpol_i` on the first PCLK edge.
- **First edge:** `ss_i` falls in cycle 0 (en=1 sampled at edge 1). The first SCLK edge then appears after `half` PCLK edges from edge 1.
- **Steady state:**
  - SCLK period = `BaudRateDivisor_o` PCLK cycles, 50% duty.
  - 16 edges per byte = `(divisor/2)*16` PCLK cycles, matching the slave-select window.
- **Ticks:** pulse width is exactly 1 PCLK. Spacing between consecutive ticks = `half` cycles.
- **Divisor 2:** SCLK toggles every PCLK and a tick is asserted every cycle, alternating send/receive.
- **`cpol_i` change while IDLE:** `sclk_o` follows one cycle later. A change while ACTIVE is not supported.

## Structure
- Shared `spi_pkg`:
  - Mode encodings `SPI_RUN`=2'b00, `SPI_WAIT`=2'b01, `SPI_STOP`=2'b10.
  - `DIV_W`, `CNT_W`.
  - Function `baud_div(sppr, spr)`, reused by the slave-select stage and the bench model.
- No sub-modules: a single flat module containing the counter, the SCLK flop and the tick flops.

## Test plan
- **Reset then idle:** `PRESET_n` pulse with `cpol_i`=1, `ss_i`=1 → `sclk_o`=0 during reset, 1 one cycle after release; ticks stay 0.
- **Mode 0, divisor 12:** sppr=2, spr=1, cpol=0, cpha=0, `ss_i` low for 96 cycles →
  - `BaudRateDivisor_o`=12.
  - `sclk_o` toggles every 6 cycles, 16 edges total.
  - 8 `receive_tick_o` on rising edges, 8 `send_tick_o` on falling edges.
- **Mode 3, divisor 2:** cpol=1, cpha=1, sppr=0, spr=0 →
  - SCLK toggles every cycle, idle high.
  - The first tick is `send_tick_o` on the falling edge, then alternating.
- **Max divisor:** sppr=7, spr=7 → divisor 0x800; first edge 1024 cycles after enable.
- **Abort:** `ss_i` rises 3 cycles after the 5th edge → next cycle `sclk_o`=`cpol_i`, count 0, no further ticks. Re-assertion restarts cleanly from a full `half`.
- **Wait gating:** `spi_mode_i`=01, `spiswai_i`=1 with `ss_i`=0 → no SCLK activity. Deasserting `spiswai_i` resumes with the first edge `half` cycles later.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, datapath widths and the baud-rate
// divisor helper. The same divisor function is used by the slave-select stage
// so that both stages agree on the transfer window length.
package spi_pkg;

  // Width of the baud-rate divisor and of the half-period counter.
  localparam int DIV_W = 12;
  localparam int CNT_W = 11;

  // SPI operating modes as programmed over APB. 2'b11 also means stop.
  typedef enum logic [1:0] {
    SPI_RUN  = 2'b00,
    SPI_WAIT = 2'b01,
    SPI_STOP = 2'b10
  } spi_mode_e;

  // Divisor = (sppr + 1) * 2^(spr + 1). The shift amount is widened first so
  // that spr = 7 gives a shift of 8 rather than wrapping to 0.
  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sppr,
                                                input logic [2:0] spr);
    logic [DIV_W-1:0] base;
    logic [3:0]       shamt;
    base  = DIV_W'(sppr) + DIV_W'(1);
    shamt = {1'b0, spr} + 4'd1;
    return base << shamt;
  endfunction

endpackage : spi_pkg

// File: rtl/spi_baud_generator.sv
// SPI master serial clock generator. Divides PCLK by the programmed baud-rate
// divisor, holds SCLK at its idle level whenever the transfer is not enabled,
// and issues one-PCLK send/receive strobes aligned with each SCLK edge.
module spi_baud_generator
  import spi_pkg::*;
#(
  parameter int DIV_W = spi_pkg::DIV_W,
  parameter int CNT_W = spi_pkg::CNT_W
) (
  input  logic             PCLK,
  input  logic             PRESET_n,
  input  logic [1:0]       spi_mode_i,
  input  logic             spiswai_i,
  input  logic             mstr_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  input  logic [2:0]       sppr_i,
  input  logic [2:0]       spr_i,
  input  logic             ss_i,
  output logic             sclk_o,
  output logic             send_tick_o,
  output logic             receive_tick_o,
  output logic [DIV_W-1:0] BaudRateDivisor_o
);

  logic [DIV_W-1:0] divisor;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] half_m1;
  logic             mode_ok;
  logic             en;
  logic             leading_edge;

  logic [CNT_W-1:0] count_reg, count_next;
  logic             sclk_reg, sclk_next;
  logic             send_reg, send_next;
  logic             recv_reg, recv_next;

  // Divisor is purely combinational so the slave-select stage sees it at once.
  assign divisor           = DIV_W'(baud_div(sppr_i, spr_i));
  assign BaudRateDivisor_o = divisor;

  // Half period in PCLK cycles; minimum is 1, so half_m1 never underflows.
  assign half    = CNT_W'(divisor >> 1);
  assign half_m1 = half - CNT_W'(1);

  // Run mode always clocks; wait mode clocks only when stop-in-wait is clear.
  assign mode_ok = (spi_mode_i == SPI_RUN) ||
                   ((spi_mode_i == SPI_WAIT) && !spiswai_i);
  assign en      = mstr_i && !ss_i && mode_ok;

  // An edge leaving the idle level is the leading edge of an SCLK period.
  assign leading_edge = (sclk_reg == cpol_i);

  // Next-state logic: idle parking, half-period counting and edge strobes.
  always_comb begin
    count_next = count_reg;
    sclk_next  = sclk_reg;
    send_next  = 1'b0;
    recv_next  = 1'b0;
    if (!en) begin
      // Parking immediately drops any partially counted half period, so an
      // aborted transfer never emits a stray edge later.
      count_next = '0;
      sclk_next  = cpol_i;
    end else if (count_reg >= half_m1) begin
      // '>=' rather than '==' so a divisor shrunk mid-count still wraps.
      count_next = '0;
      sclk_next  = ~sclk_reg;
      // cpha=0 samples on the leading edge, cpha=1 on the trailing edge;
      // the other edge shifts. Exactly one strobe per edge.
      if (leading_edge ^ cpha_i) begin
        recv_next = 1'b1;
      end else begin
        send_next = 1'b1;
      end
    end else begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  // State and output registers; strobes are registered alongside SCLK so they
  // assert in the same cycle the SCLK edge appears.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      count_reg <= '0;
      sclk_reg  <= 1'b0;
      send_reg  <= 1'b0;
      recv_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      sclk_reg  <= sclk_next;
      send_reg  <= send_next;
      recv_reg  <= recv_next;
    end
  end

  assign sclk_o         = sclk_reg;
  assign send_tick_o    = send_reg;
  assign receive_tick_o = recv_reg;

endmodule : spi_baud_generator

// File: tb/tb_spi_baud_generator.sv
// Directed bench for spi_baud_generator: divisor and enable tables plus
// hand-timed sequences for transfer windows, abort, wait gating and reset.
module tb_spi_baud_generator;
  import spi_pkg::*;

  logic        PCLK;
  logic        PRESET_n;
  logic [1:0]  spi_mode_i;
  logic        spiswai_i;
  logic        mstr_i;
  logic        cpol_i;
  logic        cpha_i;
  logic [2:0]  sppr_i;
  logic [2:0]  spr_i;
  logic        ss_i;
  logic        sclk_o;
  logic        send_tick_o;
  logic        receive_tick_o;
  logic [11:0] BaudRateDivisor_o;

  int n_cmp = 0;
  int n_err = 0;

  spi_baud_generator dut (
    .PCLK              (PCLK),
    .PRESET_n          (PRESET_n),
    .spi_mode_i        (spi_mode_i),
    .spiswai_i         (spiswai_i),
    .mstr_i            (mstr_i),
    .cpol_i            (cpol_i),
    .cpha_i            (cpha_i),
    .sppr_i            (sppr_i),
    .spr_i             (spr_i),
    .ss_i              (ss_i),
    .sclk_o            (sclk_o),
    .send_tick_o       (send_tick_o),
    .receive_tick_o    (receive_tick_o),
    .BaudRateDivisor_o (BaudRateDivisor_o)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Hard stop in case anything stalls.
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0]  sppr;
    logic [2:0]  spr;
    logic [11:0] exp_div;
  } div_vec_t;

  typedef struct {
    logic [1:0] mode;
    logic       swai;
    logic       mstr;
    logic       ss;
    logic       exp_active;
  } en_vec_t;

  div_vec_t div_tab[9];
  en_vec_t  en_tab[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Configure, optionally park in idle first, then enable and follow ncyc
  // PCLK edges. Edge e (1-based) is expected exactly at cycle e*half after
  // enable; odd-numbered edges are leading edges.
  task automatic run_window(input string tag, input logic [1:0] mode, input logic swai,
                            input logic cp, input logic ph, input logic [2:0] pp,
                            input logic [2:0] rr, input int half, input int ncyc,
                            input bit do_idle);
    int   nedge, nsend, nrecv, e, exp_edges, exp_lead, exp_trail;
    logic prev, eclk, es, er, leading;
    nedge = 0; nsend = 0; nrecv = 0;
    spi_mode_i = mode; spiswai_i = swai; mstr_i = 1'b1;
    cpol_i = cp; cpha_i = ph; sppr_i = pp; spr_i = rr;
    if (do_idle) begin
      ss_i = 1'b1;
      step();
      check({tag, " idle sclk"}, 32'(sclk_o), 32'(cp));
    end
    ss_i = 1'b0;
    prev = sclk_o;
    for (int k = 1; k <= ncyc; k++) begin
      step();
      e    = k / half;
      eclk = cp ^ e[0];
      es = 1'b0; er = 1'b0;
      if ((k % half) == 0) begin
        leading = e[0];
        er = leading ^ ph;
        es = ~er;
      end
      check($sformatf("%s sclk k=%0d", tag, k), 32'(sclk_o), 32'(eclk));
      check($sformatf("%s send k=%0d", tag, k), 32'(send_tick_o), 32'(es));
      check($sformatf("%s recv k=%0d", tag, k), 32'(receive_tick_o), 32'(er));
      if (sclk_o !== prev) nedge++;
      if (send_tick_o) nsend++;
      if (receive_tick_o) nrecv++;
      prev = sclk_o;
    end
    exp_edges = ncyc / half;
    exp_lead  = (exp_edges + 1) / 2;
    exp_trail = exp_edges / 2;
    check({tag, " edges"}, 32'(nedge), 32'(exp_edges));
    check({tag, " recv count"}, 32'(nrecv), 32'(ph ? exp_trail : exp_lead));
    check({tag, " send count"}, 32'(nsend), 32'(ph ? exp_lead : exp_trail));
    $display("window %s: div=%0d cycles=%0d edges=%0d send=%0d recv=%0d",
             tag, BaudRateDivisor_o, ncyc, nedge, nsend, nrecv);
  endtask

  initial begin
    // sppr, spr, expected (sppr+1)*2^(spr+1)
    div_tab[0] = '{3'd0, 3'd0, 12'd2};
    div_tab[1] = '{3'd2, 3'd1, 12'd12};
    div_tab[2] = '{3'd7, 3'd7, 12'h800};
    div_tab[3] = '{3'd1, 3'd0, 12'd4};
    div_tab[4] = '{3'd0, 3'd7, 12'd256};
    div_tab[5] = '{3'd3, 3'd2, 12'd32};
    div_tab[6] = '{3'd5, 3'd3, 12'd96};
    div_tab[7] = '{3'd7, 3'd0, 12'd16};
    div_tab[8] = '{3'd4, 3'd6, 12'd640};

    // mode, spiswai, mstr, ss, expect SCLK to start
    en_tab[0] = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b1};
    en_tab[1] = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
    en_tab[2] = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b1};
    en_tab[3] = '{2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
    en_tab[4] = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0};
    en_tab[5] = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0};
    en_tab[6] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    en_tab[7] = '{2'b00, 1'b0, 1'b1, 1'b1, 1'b0};

    PRESET_n = 1'b1;
    spi_mode_i = SPI_RUN; spiswai_i = 1'b0; mstr_i = 1'b1;
    cpol_i = 1'b1; cpha_i = 1'b0; sppr_i = 3'd0; spr_i = 3'd0; ss_i = 1'b1;

    // Reset then idle: sclk held at 0 in reset, follows cpol one edge later.
    #2 PRESET_n = 1'b0;
    step(); step();
    check("reset sclk", 32'(sclk_o), 32'd0);
    check("reset send", 32'(send_tick_o), 32'd0);
    check("reset recv", 32'(receive_tick_o), 32'd0);
    PRESET_n = 1'b1;
    step();
    check("post-reset sclk", 32'(sclk_o), 32'd1);
    check("post-reset send", 32'(send_tick_o), 32'd0);
    check("post-reset recv", 32'(receive_tick_o), 32'd0);
    $display("reset: sclk=%0b send=%0b recv=%0b", sclk_o, send_tick_o, receive_tick_o);
    cpol_i = 1'b0;
    step();
    check("idle cpol follow", 32'(sclk_o), 32'd0);

    // Divisor table.
    for (int i = 0; i < 9; i++) begin
      sppr_i = div_tab[i].sppr;
      spr_i  = div_tab[i].spr;
      #1;
      check($sformatf("divisor[%0d]", i), 32'(BaudRateDivisor_o), 32'(div_tab[i].exp_div));
      $display("div vec %0d: sppr=%0d spr=%0d div=%0d", i, sppr_i, spr_i, BaudRateDivisor_o);
    end

    // Enable table at divisor 2, cpol=0, cpha=0: one edge after enabling,
    // an active generator shows a rising SCLK with a receive strobe.
    sppr_i = 3'd0; spr_i = 3'd0; cpol_i = 1'b0; cpha_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ss_i = 1'b1; mstr_i = 1'b1; spi_mode_i = SPI_RUN; spiswai_i = 1'b0;
      step();
      spi_mode_i = en_tab[i].mode; spiswai_i = en_tab[i].swai;
      mstr_i = en_tab[i].mstr; ss_i = en_tab[i].ss;
      step();
      check($sformatf("enable[%0d] sclk", i), 32'(sclk_o), 32'(en_tab[i].exp_active));
      check($sformatf("enable[%0d] recv", i), 32'(receive_tick_o), 32'(en_tab[i].exp_active));
      check($sformatf("enable[%0d] send", i), 32'(send_tick_o), 32'd0);
      $display("en vec %0d: mode=%0b swai=%0b mstr=%0b ss=%0b sclk=%0b",
               i, spi_mode_i, spiswai_i, mstr_i, ss_i, sclk_o);
    end
    ss_i = 1'b1; spi_mode_i = SPI_RUN; spiswai_i = 1'b0; mstr_i = 1'b1;
    step();

    // Mode 0, divisor 12: one byte window of 96 cycles.
    run_window("mode0 div12", SPI_RUN, 1'b0, 1'b0, 1'b0, 3'd2, 3'd1, 6, 96, 1'b1);
    check("mode0 divisor", 32'(BaudRateDivisor_o), 32'd12);
    ss_i = 1'b1;
    step();
    check("mode0 end sclk", 32'(sclk_o), 32'd0);

    // Mode 3, divisor 2: toggles every cycle, first strobe is send.
    run_window("mode3 div2", SPI_RUN, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 1, 16, 1'b1);
    ss_i = 1'b1;
    step();
    check("mode3 end sclk", 32'(sclk_o), 32'd1);

    // Max divisor: first edge 1024 cycles after enable.
    run_window("max div", SPI_RUN, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7, 1024, 1030, 1'b1);
    ss_i = 1'b1;
    step();

    // Abort 3 cycles after the 5th edge, then restart from a full half.
    run_window("abort pre", SPI_RUN, 1'b0, 1'b0, 1'b0, 3'd2, 3'd1, 6, 33, 1'b1);
    check("abort pre sclk high", 32'(sclk_o), 32'd1);
    ss_i = 1'b1;
    step();
    check("abort sclk", 32'(sclk_o), 32'd0);
    check("abort send", 32'(send_tick_o), 32'd0);
    check("abort recv", 32'(receive_tick_o), 32'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("abort idle ticks k=%0d", k),
            32'({sclk_o, send_tick_o, receive_tick_o}), 32'd0);
    end
    $display("abort: sclk=%0b after ss rise", sclk_o);
    run_window("abort restart", SPI_RUN, 1'b0, 1'b0, 1'b0, 3'd2, 3'd1, 6, 24, 1'b0);
    ss_i = 1'b1;
    step();

    // Wait-mode gating: no activity while spiswai=1, resume after clearing.
    spi_mode_i = SPI_WAIT; spiswai_i = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0;
    sppr_i = 3'd2; spr_i = 3'd1;
    step();
    ss_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("wait gated k=%0d", k),
            32'({sclk_o, send_tick_o, receive_tick_o}), 32'd0);
    end
    $display("wait gating: sclk=%0b after 20 gated cycles", sclk_o);
    run_window("wait resume", SPI_WAIT, 1'b0, 1'b0, 1'b0, 3'd2, 3'd1, 6, 18, 1'b0);
    ss_i = 1'b1;
    step();

    // Asynchronous reset: takes effect without a clock edge.
    cpol_i = 1'b1; spi_mode_i = SPI_RUN;
    step();
    check("pre async sclk", 32'(sclk_o), 32'd1);
    PRESET_n = 1'b0;
    #1;
    check("async reset sclk", 32'(sclk_o), 32'd0);
    $display("async reset: sclk=%0b", sclk_o);
    step();
    PRESET_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_spi_baud_generator
